tu_scheduler: RTL and testbench
===============================

Name: tu_scheduler

Overview:
- Sits directly downstream of the transform size selector in the camera decoder's inverse quant/transform path.
- Accepts one coding-unit descriptor per handshake: CU size, selected transform size and CU origin.
- Emits the sequence of transform-unit (TU) descriptors that tile that CU, one per output handshake, to the inverse quant/transform engine.
- Decouples per-CU decisions from the per-TU processing rate via valid/ready flow control.

Parameters:
COORD_W, 12, bit width of pixel x/y coordinates (in and out)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  CU descriptor valid
in_ready  output  1  block can accept a CU descriptor
in_cu_size  input  2  00=8x8, 01=16x16, 10=32x32, 11=64x64
in_transform_size  input  2  00=4x4, 01=8x8, 10=16x16, 11=32x32
in_cu_x  input  COORD_W  CU origin x, pixels
in_cu_y  input  COORD_W  CU origin y, pixels
out_valid  output  1  TU descriptor valid
out_ready  input  1  downstream accepts TU descriptor
out_tu_x  output  COORD_W  TU origin x, pixels
out_tu_y  output  COORD_W  TU origin y, pixels
out_tu_size  output  2  effective TU size, same encoding as in_transform_size
out_first  output  1  first TU of current CU
out_last  output  1  last TU of current CU
out_clamped  output  1  requested transform size exceeded CU size and was clamped

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, sampled on the rising edge of clk.
- FSM states: IDLE, EMIT. in_ready = (state==IDLE), so in_ready=1 in the cycle after reset.
- Reset values:
  - state=IDLE, out_valid=0, TU index=0.
  - out_tu_x=0, out_tu_y=0, out_tu_size=0, out_first=0, out_last=0, out_clamped=0.
- IDLE:
  - On in_valid&&in_ready, latch all inputs and compute:
    - cu_log2 = 3+in_cu_size
    - req_log2 = 2+in_transform_size
    - tu_log2 = min(cu_log2, req_log2); clamped = (req_log2 > cu_log2)
    - n = cu_log2 - tu_log2 (0..4); count = 4^n (1..256)
  - Set index=0 and go to EMIT. out_valid rises the next cycle (latency 1 cycle from acceptance to first TU).
- EMIT:
  - out_valid=1 and all out_* fields are registered.
  - Fields are held stable while out_valid&&!out_ready.
  - On out_valid&&out_ready:
    - If index==count-1: deassert out_valid, return to IDLE.
    - Else: index+1, next descriptor presented the following cycle (one TU per cycle at full throughput).
- Descriptor generation, default raster order:
  - col = index[n-1:0], row = index>>n
  - out_tu_x = cu_x + (col<<tu_log2); out_tu_y = cu_y + (row<<tu_log2)
  - Sums are modulo 2^COORD_W.
  - out_tu_size = tu_log2-2. out_first = (index==0). out_last = (index==count-1).
  - out_clamped = clamped for every TU of the CU.
- Index counter is 8 bits. count=256 (64x64 CU with 4x4 TUs) reaches index 255 without overflow.
- CU-to-CU gap: one IDLE cycle minimum between the last TU handshake and the next CU acceptance. No CU is accepted while in EMIT.
- Single-TU CU (n=0): exactly one descriptor with out_first=out_last=1.
- Mid-operation reset: rst in any state aborts the current CU. Next cycle out_valid=0, in_ready=1, no partial-CU residue.
- in_cu_x/in_cu_y are used unaligned as given; alignment is the upstream's responsibility.

Optional Feature:
- Macro: TU_SCHEDULER_ZSCAN_EN.
- Defined: TU order is Z-scan.
  - col = even bits of index (bit0, bit2, ...); row = odd bits (bit1, bit3, ...), each limited to n bits.
- Undefined: raster order as in Behaviour.
- Interface, timing and first/last semantics are identical in both builds.

Test Plan:
- Single TU: cu_size=00, transform_size=01, origin (16,8), out_ready=1 -> one TU (16,8), size 01, first=last=1, clamped=0. in_ready returns high 2 cycles after input handshake.
- Raster tiling: cu_size=01, transform_size=00, origin (0,0), out_ready=1 -> 16 consecutive-cycle TUs (0,0),(4,0),(8,0),(12,0),(0,4)...(12,12). first only on 1st, last only on 16th.
- Clamp: cu_size=00, transform_size=11, origin (32,32) -> one TU (32,32), size 01, clamped=1, first=last=1.
- Backpressure: cu_size=10, transform_size=10, origin (64,0) -> TUs (64,0),(80,0),(64,16),(80,16). Hold out_ready=0 for 3 cycles while 2nd TU is presented -> (80,0) held stable, no TU skipped or duplicated.
- Reset mid-CU: cu_size=11, transform_size=00 (256 TUs). Assert rst after the 10th TU handshake -> next cycle out_valid=0, in_ready=1. A new CU then starts with first=1 at index 0.
- With TU_SCHEDULER_ZSCAN_EN: cu_size=01, transform_size=00, origin (0,0) -> order (0,0),(4,0),(0,4),(4,4),(8,0),(12,0),(8,4),(12,4),(0,8)..., last (12,12).

Source files
------------

// File: rtl/tu_scheduler.sv
// Splits one coding-unit descriptor into the transform-unit descriptors that tile it.
// Define TU_SCHEDULER_ZSCAN_EN to emit TUs in Z-scan order instead of raster order.
module tu_scheduler #(
    parameter int COORD_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_cu_size,
    input  logic [1:0]         in_transform_size,
    input  logic [COORD_W-1:0] in_cu_x,
    input  logic [COORD_W-1:0] in_cu_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_tu_x,
    output logic [COORD_W-1:0] out_tu_y,
    output logic [1:0]         out_tu_size,
    output logic               out_first,
    output logic               out_last,
    output logic               out_clamped
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             state;
    logic [COORD_W-1:0] cu_x;
    logic [COORD_W-1:0] cu_y;
    logic [2:0]         tu_log2;
    logic [2:0]         n;
    logic [7:0]         tu_index;
    logic [7:0]         last_idx;

    logic [2:0]         cu_log2_in;
    logic [2:0]         req_log2_in;
    logic [2:0]         tu_log2_in;
    logic [2:0]         n_in;
    logic               clamped_in;
    logic [8:0]         count_m1_in;
    logic [7:0]         next_index;
    logic [7:0]         next_pos;
    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;

    // Returns {row, col} of TU number idx within a 2^nn x 2^nn grid.
    function automatic logic [7:0] tile_pos(input logic [7:0] idx, input logic [2:0] nn);
        logic [3:0] mask;
        logic [3:0] c;
        logic [3:0] r;
        mask = 4'((5'd1 << nn) - 5'd1);
`ifdef TU_SCHEDULER_ZSCAN_EN
        for (int i = 0; i < 4; i++) begin
            c[i] = idx[2*i];
            r[i] = idx[2*i+1];
        end
`else
        c = idx[3:0];
        r = 4'(idx >> nn);
`endif
        return {r & mask, c & mask};
    endfunction

    assign in_ready = (state == IDLE);

    always_comb begin
        cu_log2_in  = 3'd3 + {1'b0, in_cu_size};
        req_log2_in = 3'd2 + {1'b0, in_transform_size};
        clamped_in  = (req_log2_in > cu_log2_in);
        tu_log2_in  = clamped_in ? cu_log2_in : req_log2_in;
        n_in        = cu_log2_in - tu_log2_in;
        count_m1_in = (9'd1 << {n_in, 1'b0}) - 9'd1;
    end

    always_comb begin
        next_index = tu_index + 8'd1;
        next_pos   = tile_pos(next_index, n);
        next_x     = cu_x + (COORD_W'(next_pos[3:0]) << tu_log2);
        next_y     = cu_y + (COORD_W'(next_pos[7:4]) << tu_log2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            tu_index    <= 8'd0;
            out_tu_x    <= '0;
            out_tu_y    <= '0;
            out_tu_size <= 2'd0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
            out_clamped <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cu_x        <= in_cu_x;
                        cu_y        <= in_cu_y;
                        tu_log2     <= tu_log2_in;
                        n           <= n_in;
                        last_idx    <= count_m1_in[7:0];
                        tu_index    <= 8'd0;
                        // TU 0 always sits at the CU origin.
                        out_tu_x    <= in_cu_x;
                        out_tu_y    <= in_cu_y;
                        out_tu_size <= 2'(tu_log2_in - 3'd2);
                        out_first   <= 1'b1;
                        out_last    <= (n_in == 3'd0);
                        out_clamped <= clamped_in;
                        out_valid   <= 1'b1;
                        state       <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            tu_index  <= next_index;
                            out_tu_x  <= next_x;
                            out_tu_y  <= next_y;
                            out_first <= 1'b0;
                            out_last  <= (next_index == last_idx);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tu_scheduler.sv
// Directed bench for tu_scheduler: table of CU descriptors plus backpressure and mid-CU reset sequences.
module tb_tu_scheduler;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_cu_size;
    logic [1:0]    in_transform_size;
    logic [CW-1:0] in_cu_x;
    logic [CW-1:0] in_cu_y;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_tu_x;
    logic [CW-1:0] out_tu_y;
    logic [1:0]    out_tu_size;
    logic          out_first;
    logic          out_last;
    logic          out_clamped;

    int total = 0;
    int bad   = 0;

    tu_scheduler #(.COORD_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cu_size(in_cu_size), .in_transform_size(in_transform_size),
        .in_cu_x(in_cu_x), .in_cu_y(in_cu_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tu_x(out_tu_x), .out_tu_y(out_tu_y), .out_tu_size(out_tu_size),
        .out_first(out_first), .out_last(out_last), .out_clamped(out_clamped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cs;
        logic [1:0] ts;
        int         x;
        int         y;
        int         count;
        logic [1:0] size;
        logic       clamped;
        int         lx;
        int         ly;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected TU origin computed from pixel sizes with div/mod rather than bit fields.
    task automatic model_xy(input int k, input int cu_px, input int tu_px, input int x0, input int y0,
                            output int ex, output int ey);
        int cols, c, r;
        cols = cu_px / tu_px;
`ifdef TU_SCHEDULER_ZSCAN_EN
        c = 0;
        r = 0;
        for (int b = 0; b < 4; b++) begin
            c += ((k >> (2*b)) & 1) * (1 << b);
            r += ((k >> (2*b+1)) & 1) * (1 << b);
        end
`else
        c = k % cols;
        r = k / cols;
`endif
        ex = (x0 + c * tu_px) % (1 << CW);
        ey = (y0 + r * tu_px) % (1 << CW);
    endtask

    task automatic send_cu(input logic [1:0] cs, input logic [1:0] ts, input int x, input int y);
        int guard;
        guard = 0;
        in_cu_size        = cs;
        in_transform_size = ts;
        in_cu_x           = CW'(x);
        in_cu_y           = CW'(y);
        in_valid          = 1'b1;
        while (!in_ready && guard < 8) begin
            step();
            guard++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("busy_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int ex, ey;
        send_cu(v.cs, v.ts, v.x, v.y);
        for (int k = 0; k < v.count; k++) begin
            model_xy(k, 8 << v.cs, 4 << v.size, v.x, v.y, ex, ey);
            chk("tu_valid", 32'(out_valid), 32'd1);
            chk("tu_x", 32'(out_tu_x), 32'(ex));
            chk("tu_y", 32'(out_tu_y), 32'(ey));
            chk("tu_size", 32'(out_tu_size), 32'(v.size));
            chk("tu_clamped", 32'(out_clamped), 32'(v.clamped));
            chk("tu_first", 32'(out_first), (k == 0) ? 32'd1 : 32'd0);
            chk("tu_last", 32'(out_last), (k == v.count - 1) ? 32'd1 : 32'd0);
            if (k == v.count - 1) begin
                chk("last_x", 32'(out_tu_x), 32'(v.lx));
                chk("last_y", 32'(out_tu_y), 32'(v.ly));
            end
            step();
        end
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{cs: 2'b00, ts: 2'b01, x: 16,   y: 8,    count: 1,   size: 2'b01, clamped: 1'b0, lx: 16,  ly: 8};
        vecs[1] = '{cs: 2'b01, ts: 2'b00, x: 0,    y: 0,    count: 16,  size: 2'b00, clamped: 1'b0, lx: 12,  ly: 12};
        vecs[2] = '{cs: 2'b00, ts: 2'b11, x: 32,   y: 32,   count: 1,   size: 2'b01, clamped: 1'b1, lx: 32,  ly: 32};
        vecs[3] = '{cs: 2'b10, ts: 2'b10, x: 64,   y: 0,    count: 4,   size: 2'b10, clamped: 1'b0, lx: 80,  ly: 16};
        vecs[4] = '{cs: 2'b11, ts: 2'b11, x: 128,  y: 64,   count: 4,   size: 2'b11, clamped: 1'b0, lx: 160, ly: 96};
        vecs[5] = '{cs: 2'b11, ts: 2'b00, x: 0,    y: 0,    count: 256, size: 2'b00, clamped: 1'b0, lx: 60,  ly: 60};
        vecs[6] = '{cs: 2'b01, ts: 2'b01, x: 4088, y: 4088, count: 4,   size: 2'b01, clamped: 1'b0, lx: 0,   ly: 0};
        vecs[7] = '{cs: 2'b10, ts: 2'b11, x: 5,    y: 3,    count: 1,   size: 2'b11, clamped: 1'b0, lx: 5,   ly: 3};
        vecs[8] = '{cs: 2'b01, ts: 2'b11, x: 100,  y: 200,  count: 1,   size: 2'b10, clamped: 1'b1, lx: 100, ly: 200};

        rst               = 1'b1;
        in_valid          = 1'b0;
        in_cu_size        = 2'b00;
        in_transform_size = 2'b00;
        in_cu_x           = '0;
        in_cu_y           = '0;
        out_ready         = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_x", 32'(out_tu_x), 32'd0);
        chk("rst_y", 32'(out_tu_y), 32'd0);
        chk("rst_size", 32'(out_tu_size), 32'd0);
        chk("rst_flags", {29'd0, out_first, out_last, out_clamped}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Backpressure: hold the second TU for three cycles.
        send_cu(2'b10, 2'b10, 64, 0);
        chk("bp_tu0_x", 32'(out_tu_x), 32'd64);
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_x", 32'(out_tu_x), 32'd80);
            chk("bp_hold_y", 32'(out_tu_y), 32'd0);
            chk("bp_hold_first", 32'(out_first), 32'd0);
            step();
        end
        out_ready = 1'b1;
        chk("bp_tu1_x", 32'(out_tu_x), 32'd80);
        step();
        chk("bp_tu2_x", 32'(out_tu_x), 32'd64);
        chk("bp_tu2_y", 32'(out_tu_y), 32'd16);
        chk("bp_tu2_last", 32'(out_last), 32'd0);
        step();
        chk("bp_tu3_x", 32'(out_tu_x), 32'd80);
        chk("bp_tu3_y", 32'(out_tu_y), 32'd16);
        chk("bp_tu3_last", 32'(out_last), 32'd1);
        step();
        chk("bp_done_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a 256-TU CU, after ten handshakes.
        step();
        send_cu(2'b11, 2'b00, 0, 0);
        for (int c = 0; c < 10; c++) step();
        chk("mid_valid", 32'(out_valid), 32'd1);
`ifdef TU_SCHEDULER_ZSCAN_EN
        chk("mid_x", 32'(out_tu_x), 32'd0);
        chk("mid_y", 32'(out_tu_y), 32'd12);
`else
        chk("mid_x", 32'(out_tu_x), 32'd40);
        chk("mid_y", 32'(out_tu_y), 32'd0);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_first", 32'(out_first), 32'd0);
        run_vec('{cs: 2'b00, ts: 2'b00, x: 8, y: 8, count: 4, size: 2'b00, clamped: 1'b0, lx: 12, ly: 12});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
